regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive stalled cycles of an MDU request before it is forced a grant.
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum MDU operations issued but not yet written back.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wb_valid / wb_ready  in / out  1 / 1  pipeline writeback request / accept.
REQ-006 wb_addr / wb_data  in  5 / 32  pipeline writeback destination / value.
REQ-007 mdu_valid / mdu_ready  in / out  1 / 1  multiply-divide result request / accept.
REQ-008 mdu_addr / mdu_data  in  5 / 32  MDU result destination / value.
REQ-009 iss_valid  in  1  decode stage presents an instruction.
REQ-010 iss_rs1, iss_rs2, iss_rd  in  5 each  source and destination register addresses.
REQ-011 iss_is_mdu  in  1  instruction is a multi-cycle MDU operation.
REQ-012 iss_stall  out  1  issue blocked this cycle.
REQ-013 RegWrite / WriteAddr / WriteData  out  1 / 5 / 32  register-file write port, registered.

Function
REQ-014 Accept = valid && ready on a requester; at most one of wb_ready, mdu_ready SHALL be 1 per cycle.
REQ-015 Default priority: wb_ready = 1 always unless forced mode; mdu_ready = !wb_valid when not forced.
REQ-016 Wait counter (3+ bits) increments each cycle mdu_valid && !mdu_ready, clears on MDU accept or mdu_valid low, saturates at STARVE_LIMIT.
REQ-017 When wait counter == STARVE_LIMIT: forced mode, wb_ready = 0, mdu_ready = 1 that cycle.
REQ-018 Accepted request SHALL appear on WriteAddr/WriteData exactly 1 cycle later; RegWrite = 1 that cycle iff accepted addr != 0.
REQ-019 No accept in a cycle: RegWrite = 0 next cycle; WriteAddr/WriteData hold previous values.
REQ-020 Scoreboard: 32-bit pending mask sb; bit 0 permanently 0.
REQ-021 Issue accept = iss_valid && !iss_stall; if iss_is_mdu and iss_rd != 0, set sb[iss_rd] at the edge.
REQ-022 MDU accept clears sb[mdu_addr] at the same edge RegWrite is registered, so a dependent issue unblocks the cycle the write is on the port (write-through forwarding covers it).
REQ-023 iss_stall = iss_valid && (sb[iss_rs1] || sb[iss_rs2] || sb[iss_rd] || (iss_is_mdu && outstanding == MAX_OUTSTANDING)); evaluated on registered sb/outstanding only.
REQ-024 Outstanding counter: +1 on MDU issue accept, -1 on MDU accept, unchanged if both same cycle; MDU to x0 counts too.
REQ-025 Set and clear of same sb bit in one cycle is impossible by REQ-023 (WAW stall); if both occur, set wins.
REQ-026 mdu_valid with outstanding == 0 is a protocol error: still accepted and written, counter holds at 0.
REQ-027 wb_valid without acceptance: pipeline holds wb_addr/wb_data stable until accepted.

Reset
REQ-028 rst high at an edge: sb = 0, outstanding = 0, wait counter = 0, RegWrite = 0, WriteAddr = 0, WriteData = 0.
REQ-029 During rst cycle: wb_ready = 0, mdu_ready = 0, iss_stall = iss_valid; pending requests mid-flight discarded.
REQ-030 First cycle after rst low: normal arbitration, no write from pre-reset accepts.

Verification
REQ-031 wb_valid, addr 5, data 0xDEADBEEF, no MDU -> next cycle RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF.
REQ-032 Issue MDU rd=7; next cycle issue rs1=7 -> iss_stall=1 until MDU result to 7 accepted; iss_stall=0 the cycle RegWrite=1 WriteAddr=7.
REQ-033 wb_valid and mdu_valid held high continuously -> mdu_ready=0 for 4 cycles, 1 on 5th, wb_ready=0 that cycle; MDU data written next cycle.
REQ-034 Two MDU issues (rd=3, rd=4) outstanding, third MDU issue rd=9 -> iss_stall=1; MDU result rd=3 accepted -> third issue accepted next cycle.
REQ-035 MDU result addr 0, data 0x1234 -> mdu_ready=1, next cycle RegWrite=0, outstanding decrements.
REQ-036 rst asserted with sb[7]=1 and MDU accept pending -> next cycle sb=0, RegWrite=0, iss_stall=0 for rs1=7 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback, MDU-result, issue and register-file-write signals
// shared between the arbiter and its surrounding pipeline.
interface regfile_wb_arbiter_if;
  // Pipeline writeback request.
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  // Multiply/divide result request.
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;

  // Decode-stage issue check.
  logic        iss_valid;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_is_mdu;
  logic        iss_stall;

  // Registered register-file write port.
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;

  // Pipeline side: drives requests, observes grants and the write port.
  modport master (
    output wb_valid, wb_addr, wb_data,
    output mdu_valid, mdu_addr, mdu_data,
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_is_mdu,
    input  wb_ready, mdu_ready, iss_stall,
    input  RegWrite, WriteAddr, WriteData
  );

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  mdu_valid, mdu_addr, mdu_data,
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_is_mdu,
    output wb_ready, mdu_ready, iss_stall,
    output RegWrite, WriteAddr, WriteData
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback and the
// multi-cycle MDU, with anti-starvation for the MDU and a pending-destination
// scoreboard that stalls issue on RAW/WAW hazards against in-flight MDU ops.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned WaitBits = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WaitW    = (WaitBits > 3) ? WaitBits : 3;
  localparam int unsigned OutBits  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OutW     = (OutBits > 1) ? OutBits : 1;

  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);
  localparam logic [OutW-1:0]  OutMax  = OutW'(MAX_OUTSTANDING);

  logic [WaitW-1:0] wait_q, wait_d;
  logic [OutW-1:0]  outs_q, outs_d;
  logic [31:0]      sb_q, sb_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic forced;
  logic mdu_sel;
  logic wb_acc;
  logic mdu_acc;
  logic hazard;
  logic iss_acc;
  logic mdu_issue;
  logic outs_dec;

  // Arbitration and issue hazard check, from registered state only.
  always_comb begin
    forced  = (wait_q == WaitMax);
    // The MDU takes the port when starved, or when the pipeline has nothing to
    // write; otherwise the pipeline keeps the port so only one side is ready.
    mdu_sel = forced || (bus.mdu_valid && !bus.wb_valid);

    bus.mdu_ready = !rst && mdu_sel;
    bus.wb_ready  = !rst && !mdu_sel;

    wb_acc  = bus.wb_valid && bus.wb_ready;
    mdu_acc = bus.mdu_valid && bus.mdu_ready;

    hazard = sb_q[bus.iss_rs1] || sb_q[bus.iss_rs2] || sb_q[bus.iss_rd] ||
             (bus.iss_is_mdu && (outs_q == OutMax));

    bus.iss_stall = bus.iss_valid && (rst || hazard);
    iss_acc       = bus.iss_valid && !bus.iss_stall;
    mdu_issue     = iss_acc && bus.iss_is_mdu;
    // A result with nothing outstanding is still written but never underflows.
    outs_dec      = mdu_acc && (outs_q != '0);
  end

  // Next-state for the write port, scoreboard, outstanding and wait counters.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (mdu_acc) begin
      we_d    = (bus.mdu_addr != 5'd0);
      waddr_d = bus.mdu_addr;
      wdata_d = bus.mdu_data;
    end else if (wb_acc) begin
      we_d    = (bus.wb_addr != 5'd0);
      waddr_d = bus.wb_addr;
      wdata_d = bus.wb_data;
    end

    // Clear first so a same-cycle set of the same bit wins.
    sb_d = sb_q;
    if (mdu_acc) begin
      sb_d[bus.mdu_addr] = 1'b0;
    end
    if (mdu_issue && (bus.iss_rd != 5'd0)) begin
      sb_d[bus.iss_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;

    outs_d = outs_q;
    unique case ({mdu_issue, outs_dec})
      2'b10:   outs_d = outs_q + OutW'(1);
      2'b01:   outs_d = outs_q - OutW'(1);
      default: outs_d = outs_q;
    endcase

    if (bus.mdu_valid && !bus.mdu_ready) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
    end else begin
      wait_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      outs_q  <= '0;
      sb_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wait_q  <= wait_d;
      outs_q  <= outs_d;
      sb_q    <= sb_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.RegWrite  = we_q;
  assign bus.WriteAddr = waddr_q;
  assign bus.WriteData = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a set/count reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned StarveLimit = 4;
  localparam int unsigned MaxOut      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .STARVE_LIMIT   (StarveLimit),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic mdu, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd);
    bus.iss_valid  = v;
    bus.iss_is_mdu = mdu;
    bus.iss_rs1    = rs1;
    bus.iss_rs2    = rs2;
    bus.iss_rd     = rd;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = v;
    bus.mdu_addr  = a;
    bus.mdu_data  = d;
  endtask

  task automatic idle();
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    drive_issue(1'b1, 1'b0, 5'd3, 5'd4, 5'd5);
    drive_wb(1'b1, 5'd1, 32'h1111_1111);
    drive_mdu(1'b1, 5'd2, 32'h2222_2222);
    #1;
    n_checks++; if (bus.wb_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_wb_ready: got %b want 0", bus.wb_ready); end
    n_checks++; if (bus.mdu_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_mdu_ready: got %b want 0", bus.mdu_ready); end
    n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
      $display("FAIL reset_iss_stall: got %b want 1", bus.iss_stall); end
    tick();
    n_checks++; if (bus.RegWrite !== 1'b0) begin n_fail++;
      $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite); end
    n_checks++; if (bus.WriteAddr !== 5'd0) begin n_fail++;
      $display("FAIL reset_waddr: got %0d want 0", bus.WriteAddr); end
    n_checks++; if (bus.WriteData !== 32'd0) begin n_fail++;
      $display("FAIL reset_wdata: got %h want 0", bus.WriteData); end
    idle();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.RegWrite !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_regwrite: got %b want 0", bus.RegWrite); end
  endtask

  task automatic test_wb_write();
    apply_reset();
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (bus.wb_ready !== 1'b1) begin n_fail++;
      $display("FAIL wb_ready: got %b want 1", bus.wb_ready); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
      begin n_fail++; $display("FAIL wb_write: got %b/%0d/%h want 1/5/deadbeef",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData); end
    tick();
    n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
      begin n_fail++; $display("FAIL wb_hold: got %b/%0d/%h want 0/5/deadbeef",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData); end
  endtask

  task automatic test_dependency();
    apply_reset();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++;
      $display("FAIL dep_first_issue: got %b want 0", bus.iss_stall); end
    tick();
    drive_issue(1'b1, 1'b0, 5'd7, 5'd0, 5'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
        $display("FAIL dep_stall_c%0d: got %b want 1", c, bus.iss_stall); end
      tick();
    end
    drive_mdu(1'b1, 5'd7, 32'h7777_0007);
    #1;
    n_checks++; if (bus.mdu_ready !== 1'b1) begin n_fail++;
      $display("FAIL dep_mdu_ready: got %b want 1", bus.mdu_ready); end
    n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
      $display("FAIL dep_stall_accept_cycle: got %b want 1", bus.iss_stall); end
    tick();
    drive_mdu(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++;
      $display("FAIL dep_unstall: got %b want 0", bus.iss_stall); end
    n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b1, 5'd7, 32'h7777_0007})
      begin n_fail++; $display("FAIL dep_write: got %b/%0d/%h want 1/7/77770007",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData); end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    apply_reset();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
    tick();
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drive_wb(1'b1, 5'd2, 32'hAAAA_0002);
    drive_mdu(1'b1, 5'd9, 32'hBBBB_0009);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if ({bus.mdu_ready, bus.wb_ready} !== 2'b01) begin n_fail++;
        $display("FAIL starve_wait_c%0d: got mdu/wb %b%b want 01", c, bus.mdu_ready,
                 bus.wb_ready); end
      tick();
    end
    #1;
    n_checks++; if ({bus.mdu_ready, bus.wb_ready} !== 2'b10) begin n_fail++;
      $display("FAIL starve_forced: got mdu/wb %b%b want 10", bus.mdu_ready, bus.wb_ready); end
    tick();
    drive_mdu(1'b0, 5'd0, 32'd0);
    n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b1, 5'd9, 32'hBBBB_0009})
      begin n_fail++; $display("FAIL starve_write: got %b/%0d/%h want 1/9/bbbb0009",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData); end
    #1;
    n_checks++; if (bus.wb_ready !== 1'b1) begin n_fail++;
      $display("FAIL starve_release: got %b want 1", bus.wb_ready); end
    tick();
    idle();
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
    tick();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd4);
    tick();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
      $display("FAIL limit_stall: got %b want 1", bus.iss_stall); end
    tick();
    drive_mdu(1'b1, 5'd3, 32'h0000_0333);
    #1;
    n_checks++; if ({bus.mdu_ready, bus.iss_stall} !== 2'b11) begin n_fail++;
      $display("FAIL limit_accept_cycle: got mdu/stall %b%b want 11", bus.mdu_ready,
               bus.iss_stall); end
    tick();
    drive_mdu(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++;
      $display("FAIL limit_unstall: got %b want 0", bus.iss_stall); end
    tick();
    drive_issue(1'b1, 1'b0, 5'd9, 5'd0, 5'd1);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
      $display("FAIL limit_third_pending: got %b want 1", bus.iss_stall); end
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd10);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
      $display("FAIL limit_full_again: got %b want 1", bus.iss_stall); end
    idle();
  endtask

  task automatic test_x0_result();
    apply_reset();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++;
      $display("FAIL x0_full: got %b want 1", bus.iss_stall); end
    drive_mdu(1'b1, 5'd0, 32'h0000_1234);
    #1;
    n_checks++; if (bus.mdu_ready !== 1'b1) begin n_fail++;
      $display("FAIL x0_mdu_ready: got %b want 1", bus.mdu_ready); end
    tick();
    drive_mdu(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b0, 5'd0, 32'h1234})
      begin n_fail++; $display("FAIL x0_write: got %b/%0d/%h want 0/0/1234",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData); end
    n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++;
      $display("FAIL x0_decrement: got %b want 0", bus.iss_stall); end
    tick();
    idle();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
    tick();
    drive_issue(1'b1, 1'b0, 5'd7, 5'd0, 5'd1);
    drive_mdu(1'b1, 5'd7, 32'h0000_ABCD);
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.mdu_ready, bus.iss_stall} !== 2'b01) begin n_fail++;
      $display("FAIL rstmid_outputs: got mdu/stall %b%b want 01", bus.mdu_ready,
               bus.iss_stall); end
    tick();
    rst = 1'b0;
    drive_mdu(1'b0, 5'd0, 32'd0);
    n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b0, 5'd0, 32'd0})
      begin n_fail++; $display("FAIL rstmid_port: got %b/%0d/%h want 0/0/0",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData); end
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_sb_cleared: got %b want 0", bus.iss_stall); end
    tick();
    idle();
  endtask

  // Randomized traffic against a reference kept as a set of pending
  // destinations, a count of in-flight MDU ops and the age of the MDU request.
  task automatic test_random();
    bit          pend[32];
    int          outs = 0;
    int          age = 0;
    bit          e_we = 0;
    logic [4:0]  e_wa = '0;
    logic [31:0] e_wd = '0;
    bit          wb_pend = 0;
    bit          mdu_pend = 0;
    bit          mdu_wins, m_acc, w_acc, i_acc, e_stall;
    int          cnt;
    logic [4:0]  pick;

    apply_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!wb_pend && ($urandom_range(0, 1) == 1)) begin
        wb_pend = 1;
        drive_wb(1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      bus.wb_valid = wb_pend;
      if (!mdu_pend && ($urandom_range(0, 2) == 0)) begin
        cnt  = 0;
        pick = 5'($urandom_range(0, 3));
        for (int r = 1; r < 32; r++) begin
          if (pend[r]) begin
            cnt++;
            if ($urandom_range(1, cnt) == 1) pick = 5'(r);
          end
        end
        mdu_pend = 1;
        drive_mdu(1'b1, pick, $urandom);
      end
      bus.mdu_valid = mdu_pend;
      drive_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
      #1;
      mdu_wins = (age == StarveLimit) || (bus.mdu_valid && !bus.wb_valid);
      e_stall  = bus.iss_valid && (pend[bus.iss_rs1] || pend[bus.iss_rs2] ||
                                   pend[bus.iss_rd] || (bus.iss_is_mdu && outs == MaxOut));
      n_checks++; if ({bus.mdu_ready, bus.wb_ready} !== {mdu_wins, !mdu_wins}) begin n_fail++;
        $display("FAIL rand_ready cyc%0d: got mdu/wb %b%b want %b%b", cyc, bus.mdu_ready,
                 bus.wb_ready, mdu_wins, !mdu_wins); end
      n_checks++; if (bus.iss_stall !== e_stall) begin n_fail++;
        $display("FAIL rand_stall cyc%0d: got %b want %b", cyc, bus.iss_stall, e_stall); end

      m_acc = bus.mdu_valid && mdu_wins;
      w_acc = bus.wb_valid && !mdu_wins;
      i_acc = bus.iss_valid && !e_stall;
      e_we  = 0;
      if (m_acc) begin
        e_we = (bus.mdu_addr != 0); e_wa = bus.mdu_addr; e_wd = bus.mdu_data;
        pend[bus.mdu_addr] = 0;
      end else if (w_acc) begin
        e_we = (bus.wb_addr != 0); e_wa = bus.wb_addr; e_wd = bus.wb_data;
      end
      if (i_acc && bus.iss_is_mdu && bus.iss_rd != 0) pend[bus.iss_rd] = 1;
      if (m_acc && outs > 0) outs--;
      if (i_acc && bus.iss_is_mdu) outs++;
      if (bus.mdu_valid && !m_acc) age = (age < StarveLimit) ? age + 1 : StarveLimit;
      else age = 0;
      if (m_acc) mdu_pend = 0;
      if (w_acc) wb_pend = 0;

      tick();
      n_checks++; if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {e_we, e_wa, e_wd})
        begin n_fail++; $display("FAIL rand_port cyc%0d: got %b/%0d/%h want %b/%0d/%h", cyc,
                                 bus.RegWrite, bus.WriteAddr, bus.WriteData, e_we, e_wa, e_wd);
        end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_wb_write();
    test_dependency();
    test_starvation();
    test_outstanding_limit();
    test_x0_result();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
